// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its dump engine.
//   DEF_WIDTH / DEF_ADDR_W : default data and address widths
//   ZERO_REG               : index of the hardwired-zero register
//   dump_state_e           : dump engine states
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Streams every register out over a valid/ready port, index 0 first.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   dump_start             : one-cycle request, honoured only when idle
//   dump_ready             : consumer accepts the current beat
//   lookup_addr/data       : bypassed read port into the storage array
//   dump_valid/addr/data   : current beat (addr/data registered)
//   dump_busy, dump_done   : in progress / one-cycle completion pulse
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] lookup_addr,
  input  logic [WIDTH-1:0]  lookup_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  dump_state_e state, state_nxt;

  // Next beat's register. The lookup is bypassed, so a write committing on
  // the accepting edge lands in the loaded beat.
  assign lookup_addr = dump_addr + ADDR_W'(1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (dump_start) state_nxt = SEND;
      SEND:    if (dump_ready && dump_addr == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          // Beat 0 is the zero register: always 0, no lookup needed.
          if (dump_start) begin
            dump_addr <= '0;
            dump_data <= '0;
          end
        end
        SEND: begin
          // Held while stalled, so writes during a stall never touch the beat.
          if (dump_ready) begin
            if (dump_addr == LAST) begin
              dump_addr <= '0;
              dump_data <= '0;
            end else begin
              dump_addr <= lookup_addr;
              dump_data <= lookup_data;
            end
          end
        end
        default: begin
          dump_addr <= '0;
          dump_data <= '0;
        end
      endcase
    end
  end

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state != IDLE);
  assign dump_done  = (state == DONE);

endmodule

// File: rtl/regfile_bypass_dump.sv
// 2R/1W register file with write-through bypass, hardwired r0, and a
// handshaked dump port that snapshots every register without stalling
// the datapath.
// Ports:
//   Clk, Reset_n                       : clock, async active-low reset
//   ReadRegister1/2, ReadData1/2       : combinational bypassed reads
//   WriteRegister, WriteData, RegWrite : single write port
//   DumpStart, DumpReady               : dump request / consumer ready
//   DumpValid, DumpAddr, DumpData      : current dump beat
//   DumpBusy, DumpDone                 : dump in progress / done pulse
module regfile_bypass_dump
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic              DumpStart,
  input  logic              DumpReady,
  output logic              DumpValid,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [WIDTH-1:0]  DumpData,
  output logic              DumpBusy,
  output logic              DumpDone
);

  localparam int DEPTH  = 1 << ADDR_W;
  // Lookup ports: two datapath reads plus the dump engine.
  localparam int NUM_RD = 3;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
  logic [ADDR_W-1:0]             lookup_addr;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (RegWrite && WriteRegister != ZERO) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  assign rd_addr = {lookup_addr, ReadRegister2, ReadRegister1};

  // r0 wins over bypass so a discarded r0 write never shows up on a read.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rd_data[g] = (rd_addr[g] == ZERO)                        ? '0 :
                        (RegWrite && WriteRegister == rd_addr[g]) ? WriteData :
                                                                    regs[rd_addr[g]];
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];

  regfile_dump_fsm #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_dump (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .dump_start (DumpStart),
    .dump_ready (DumpReady),
    .lookup_addr(lookup_addr),
    .lookup_data(rd_data[2]),
    .dump_valid (DumpValid),
    .dump_addr  (DumpAddr),
    .dump_data  (DumpData),
    .dump_busy  (DumpBusy),
    .dump_done  (DumpDone)
  );

endmodule

// File: tb/tb_regfile_bypass_dump.sv
// Self-checking bench for regfile_bypass_dump: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (array of registers plus a dump phase/index tracker).
module tb_regfile_bypass_dump;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite, DumpStart, DumpReady;
  logic        DumpValid, DumpBusy, DumpDone;
  logic [4:0]  DumpAddr;
  logic [31:0] DumpData;

  int vectors = 0;
  int errors  = 0;

  regfile_bypass_dump dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .DumpStart    (DumpStart),
    .DumpReady    (DumpReady),
    .DumpValid    (DumpValid),
    .DumpAddr     (DumpAddr),
    .DumpData     (DumpData),
    .DumpBusy     (DumpBusy),
    .DumpDone     (DumpDone)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  int          mphase;      // 0 idle, 1 streaming beats, 2 done pulse
  logic [4:0]  midx;
  logic [31:0] mdata;

  // What a read sees right now: r0 is zero, a pending write is visible.
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWrite && WriteRegister == a) return WriteData;
    return mregs[a];
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
      mphase <= 0;
      midx   <= 5'd0;
      mdata  <= 32'd0;
    end else begin
      if (RegWrite && WriteRegister != 5'd0) mregs[WriteRegister] <= WriteData;
      case (mphase)
        0: if (DumpStart) begin
          mphase <= 1; midx <= 5'd0; mdata <= 32'd0;
        end
        1: if (DumpReady) begin
          if (midx == 5'd31) begin
            mphase <= 2; midx <= 5'd0; mdata <= 32'd0;
          end else begin
            midx  <= midx + 5'd1;
            // post-edge content of the next register == current bypassed read
            mdata <= mread(midx + 5'd1);
          end
        end
        default: mphase <= 0;
      endcase
    end
  end

  // One compare process, every falling edge once the model is initialised.
  initial begin
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      check("rd1",   ReadData1, mread(ReadRegister1));
      check("rd2",   ReadData2, mread(ReadRegister2));
      check("valid", {31'd0, DumpValid}, {31'd0, mphase == 1});
      check("busy",  {31'd0, DumpBusy},  {31'd0, mphase != 0});
      check("done",  {31'd0, DumpDone},  {31'd0, mphase == 2});
      check("daddr", {27'd0, DumpAddr},  {27'd0, midx});
      check("ddata", DumpData, mdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    DumpReady = 1'b1;
    while (!DumpDone && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, DumpDone}, 32'd1);
    tick();
  endtask

  initial begin
    Reset_n = 1'b0;
    ReadRegister1 = '0; ReadRegister2 = '0; WriteRegister = '0;
    WriteData = '0; RegWrite = 1'b0; DumpStart = 1'b0; DumpReady = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, DumpValid}, 32'd0);
    check("rst_busy",  {31'd0, DumpBusy},  32'd0);
    Reset_n = 1'b1;
    tick();

    // write-then-read
    RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 32'd42;
    tick();
    WriteData = 32'd15;
    tick();
    RegWrite = 1'b0; WriteData = 32'd8; ReadRegister1 = 5'd2; ReadRegister2 = 5'd2;
    #1;
    check("wr_r2_p1", ReadData1, 32'd15);
    check("wr_r2_p2", ReadData2, 32'd15);
    tick();
    check("wr_r2_hold", ReadData1, 32'd15);

    // decoder isolation and r0
    RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 32'd8;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd10;
    #1;
    check("iso_r10", ReadData1, 32'd0);
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'd8;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    #1;
    check("r0_byp_p1", ReadData1, 32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("r0_p1", ReadData1, 32'd0);
    check("r0_p2", ReadData2, 32'd0);

    // bypass
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEAD; ReadRegister1 = 5'd5;
    #1;
    check("bypass_r5", ReadData1, 32'hDEAD);
    WriteRegister = 5'd0; ReadRegister1 = 5'd0;
    #1;
    check("bypass_r0", ReadData1, 32'd0);
    tick();

    // preload rK = 3K
    for (int k = 1; k < 32; k++) begin
      RegWrite = 1'b1; WriteRegister = 5'(k); WriteData = 32'(k * 3);
      tick();
    end
    RegWrite = 1'b0;

    // full dump at full throughput
    DumpStart = 1'b1; DumpReady = 1'b1;
    tick();
    DumpStart = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("full_addr", {27'd0, DumpAddr}, 32'(k));
      check("full_data", DumpData, 32'(k * 3));
      tick();
    end
    check("full_done",    {31'd0, DumpDone},  32'd1);
    check("full_done_av", {31'd0, DumpValid}, 32'd0);
    tick();
    check("full_done_off", {31'd0, DumpDone}, 32'd0);
    check("full_idle",     {31'd0, DumpBusy}, 32'd0);

    // backpressure at beat 7
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    repeat (7) tick();
    check("bp_addr7", {27'd0, DumpAddr}, 32'd7);
    DumpReady = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'd99;
    for (int i = 0; i < 4; i++) begin
      tick();
      RegWrite = 1'b0;
      check("bp_hold_addr", {27'd0, DumpAddr}, 32'd7);
      check("bp_hold_data", DumpData, 32'd21);
    end
    DumpReady = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'd77;
    tick();
    RegWrite = 1'b0;
    check("bp_addr8", {27'd0, DumpAddr}, 32'd8);
    check("bp_data8", DumpData, 32'd77);
    drain("bp_drain");

    // reset mid-dump
    DumpStart = 1'b1;
    tick();
    DumpStart = 1'b0;
    repeat (12) tick();
    check("rm_addr12", {27'd0, DumpAddr}, 32'd12);
    check("rm_data12", DumpData, 32'd36);
    Reset_n = 1'b0; ReadRegister1 = 5'd12; ReadRegister2 = 5'd7;
    #1;
    check("rm_valid", {31'd0, DumpValid}, 32'd0);
    check("rm_addr",  {27'd0, DumpAddr},  32'd0);
    check("rm_data",  DumpData, 32'd0);
    check("rm_r12",   ReadData1, 32'd0);
    check("rm_r7",    ReadData2, 32'd0);
    repeat (3) begin
      tick();
      check("rm_nodone", {31'd0, DumpDone}, 32'd0);
    end
    Reset_n = 1'b1;
    tick(); tick();
    check("rm_noresume", {31'd0, DumpValid}, 32'd0);
    // restart, with a write to r0 on the start edge
    DumpStart = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h1234;
    tick();
    DumpStart = 1'b0; RegWrite = 1'b0;
    check("rs_valid", {31'd0, DumpValid}, 32'd1);
    check("rs_addr",  {27'd0, DumpAddr},  32'd0);
    check("rs_data",  DumpData, 32'd0);
    drain("rs_drain");

    // randomized traffic, checked by the compare process
    for (int c = 0; c < 3000; c++) begin
      ReadRegister1 = 5'($urandom);
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom);
      RegWrite      = 1'($urandom);
      WriteRegister = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom);
      WriteData     = $urandom;
      DumpStart     = ($urandom_range(0, 15) == 0);
      DumpReady     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_dump.md
# regfile_bypass_dump

Two-read/one-write 32×32 MIPS register file for the single-cycle CPU datapath. Reads are combinational with write-through bypass, and register 0 is hardwired to zero. A handshaked dump port streams all 32 registers out in order, so the keyboard-input simulation harness can snapshot architectural state without stalling the datapath.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 5, register address width; depth is 2^ADDR_W

Ports:
- Clk  input  1  clock, positive-edge triggered
- Reset_n  input  1  asynchronous, active-low reset
- ReadRegister1  input  ADDR_W  read port 1 address
- ReadRegister2  input  ADDR_W  read port 2 address
- ReadData1  output  WIDTH  read port 1 data (combinational)
- ReadData2  output  WIDTH  read port 2 data (combinational)
- WriteRegister  input  ADDR_W  write address
- WriteData  input  WIDTH  write data
- RegWrite  input  1  write enable, active high
- DumpStart  input  1  single-cycle request to begin a dump
- DumpReady  input  1  consumer accepts the current beat
- DumpValid  output  1  DumpAddr/DumpData hold a valid beat
- DumpAddr  output  ADDR_W  register index of the current beat
- DumpData  output  WIDTH  register contents of the current beat
- DumpBusy  output  1  a dump is in progress
- DumpDone  output  1  one-cycle pulse after the final beat is accepted

## Operation
**Writes**
- On posedge Clk, if RegWrite=1 and WriteRegister≠0, then reg[WriteRegister] ← WriteData.
- Writes to register 0 are discarded.

**Reads**
- ReadDataN = 0 when ReadRegisterN = 0.
- Otherwise, if RegWrite=1 and WriteRegister = ReadRegisterN, ReadDataN = WriteData (bypass).
- Otherwise, ReadDataN = reg[ReadRegisterN].
- Both ports are independent. A same-address read on both ports returns identical data.

**Dump FSM** (states IDLE, SEND, DONE)
- IDLE: DumpStart=1 → SEND. Load DumpAddr=0, DumpData=0.
- SEND: DumpValid=1. A beat is accepted when DumpValid & DumpReady.
  - Accept with DumpAddr<31: DumpAddr ← DumpAddr+1. DumpData ← the post-edge value of that register, so a write committing on the same edge is included.
  - Accept with DumpAddr=31 → DONE.
- DONE: DumpDone=1 for one cycle, then → IDLE. Outputs DumpAddr and DumpData return to 0.
- DumpStart is ignored outside IDLE.
- DumpBusy=1 in SEND and DONE.

## Timing
- Reset values:
  - all 32 registers = 0
  - FSM in IDLE
  - DumpValid=0, DumpBusy=0, DumpDone=0, DumpAddr=0, DumpData=0
- Reset asserted mid-dump aborts immediately with no DumpDone pulse. The dump does not resume after reset is released.
- Write latency is one edge. The read path has zero latency, including bypass.
- Dump handshake:
  - DumpAddr and DumpData are registered and stay stable while DumpValid=1 and DumpReady=0.
  - Writes during a stall do not alter the held beat.
  - DumpValid never drops without an accept.
- Dump throughput with DumpReady held high:
  - DumpStart sampled at edge E0.
  - Beats occupy cycles after E0 through E31.
  - DumpDone is high in the cycle after E32.
  - IDLE is reached at E33.
- Simultaneous events:
  - DumpStart on the same edge as a write to reg 0: beat 0 is still 0.
  - Datapath reads and writes proceed normally throughout a dump.

## Structure
- Shared package regfile_pkg holds:
  - WIDTH and ADDR_W defaults
  - ZERO_REG = 0
  - the dump state enum (IDLE, SEND, DONE)
- Sub-module regfile_dump_fsm contains the state register, index counter, output registers and handshake logic. It reads the storage array through a combinational bypassed lookup port supplied by the top.
- The top level holds the storage array, the write decoder and the two read muxes with bypass.

## Test plan
- Write-then-read: write 42 to r2, then 15 to r2 → both ports read 15 after the second edge. With RegWrite=0 and WriteData=8, r2 still reads 15.
- Decoder isolation and r0: write 8 to r2 → r10 reads 0. Write 8 to r0 → r0 reads 0 on both ports.
- Bypass: RegWrite=1, WriteRegister=5, WriteData=0xDEAD, ReadRegister1=5 before the edge → ReadData1=0xDEAD. The same case on r0 → 0.
- Full dump: preload rK=K*3, pulse DumpStart, hold DumpReady=1 → 32 beats with DumpAddr=K and DumpData=K*3, then DumpDone pulses once at the 34th cycle.
- Backpressure: drop DumpReady for 4 cycles at beat 7 and write 99 to r7 during the stall → beat 7 holds its old value. Write 77 to r8 on the accepting edge → beat 8 shows 77.
- Reset mid-dump: deassert Reset_n at beat 12 → all outputs and registers read 0, and no DumpDone pulse. A new DumpStart after reset restarts from DumpAddr=0.
